// File: rtl/sub_serial_pkg.sv
// Shared definitions for the serial subtractor: slice width, counter sizing and FSM states.
package sub_serial_pkg;

  localparam int unsigned SliceW    = 8;
  // Largest supported slice count; sets the slice counter width.
  localparam int unsigned MaxSlices = 16;
  localparam int unsigned CntW      = $clog2(MaxSlices);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSub  = 2'd1,
    StNeg  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/sub_slice_8.sv
// Combinational 8-bit slice adder (a + b + cin) built on a generate/propagate carry network.
module sub_slice_8
  import sub_serial_pkg::*;
(
  input  logic [SliceW-1:0] a_i,
  input  logic [SliceW-1:0] b_i,
  input  logic              cin_i,
  output logic [SliceW-1:0] sum_o,
  output logic              cout_o
);

  logic [SliceW-1:0] g;
  logic [SliceW-1:0] p;
  logic [SliceW:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int unsigned i = 0; i < SliceW; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum_o  = p ^ c[SliceW-1:0];
  assign cout_o = c[SliceW];

endmodule

// File: rtl/sub_serial_32.sv
// Slice-serial subtractor D = A - B - Bin, one 8-bit slice per clock, LSB first.
// Define SUB_SERIAL_ABS_EN to return |A - B - Bin| via an extra negate pass.
module sub_serial_32
  import sub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iBin,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oD,
  output logic             oBout,
  output logic             oZ
);

  localparam int unsigned N = WIDTH / SliceW;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  nb_q, nb_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [CntW-1:0]   k_q, k_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              bout_q, bout_d;

  logic [SliceW-1:0] sl_a, sl_b, sl_sum;
  logic              sl_cout;
  logic              last_slice;

  assign last_slice = (k_q == CntW'(N - 1));

  // Operand mux: A/~B during SUB, 0/~D during NEG.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == CntW'(i)) begin
`ifdef SUB_SERIAL_ABS_EN
        if (state_q == StNeg) begin
          sl_a = '0;
          sl_b = ~d_q[i*SliceW +: SliceW];
        end else begin
          sl_a = a_q[i*SliceW +: SliceW];
          sl_b = nb_q[i*SliceW +: SliceW];
        end
`else
        sl_a = a_q[i*SliceW +: SliceW];
        sl_b = nb_q[i*SliceW +: SliceW];
`endif
      end
    end
  end

  sub_slice_8 u_slice (
    .a_i   (sl_a),
    .b_i   (sl_b),
    .cin_i (carry_q),
    .sum_o (sl_sum),
    .cout_o(sl_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    d_d     = d_q;
    k_d     = k_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    bout_d  = bout_q;

    unique case (state_q)
      StIdle: begin
        if (iValid) begin
          a_d     = iA;
          nb_d    = ~iB;
          carry_d = ~iBin;
          k_d     = '0;
          zero_d  = 1'b1;
          bout_d  = 1'b0;
          state_d = StSub;
        end
      end
      StSub: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (k_q == CntW'(i)) d_d[i*SliceW +: SliceW] = sl_sum;
        end
        carry_d = sl_cout;
        zero_d  = zero_q & (sl_sum == '0);
        k_d     = k_q + CntW'(1);
        if (last_slice) begin
          k_d     = '0;
          bout_d  = ~sl_cout;
          state_d = StDone;
`ifdef SUB_SERIAL_ABS_EN
          if (!sl_cout) begin
            carry_d = 1'b1;
            zero_d  = 1'b1;
            state_d = StNeg;
          end
`endif
        end
      end
`ifdef SUB_SERIAL_ABS_EN
      StNeg: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (k_q == CntW'(i)) d_d[i*SliceW +: SliceW] = sl_sum;
        end
        carry_d = sl_cout;
        zero_d  = zero_q & (sl_sum == '0);
        k_d     = k_q + CntW'(1);
        if (last_slice) begin
          k_d     = '0;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (iReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      nb_q    <= '0;
      d_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      d_q     <= d_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      bout_q  <= bout_d;
    end
  end

  assign oReady = (state_q == StIdle);
  assign oValid = (state_q == StDone);
  assign oD     = d_q;
  assign oBout  = bout_q;
  assign oZ     = zero_q;

endmodule

// File: tb/tb_sub_serial_32.sv
// Directed self-checking bench for sub_serial_32 (WIDTH=32); follows SUB_SERIAL_ABS_EN if defined.
module tb_sub_serial_32;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iValid;
  logic        oReady;
  logic [31:0] iA, iB;
  logic        iBin;
  logic        oValid;
  logic        iReady;
  logic [31:0] oD;
  logic        oBout;
  logic        oZ;

  int n_cmp = 0;
  int n_err = 0;

  always #5 iClk = ~iClk;

  sub_serial_32 #(.WIDTH(32)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iValid(iValid),
    .oReady(oReady),
    .iA    (iA),
    .iB    (iB),
    .iBin  (iBin),
    .oValid(oValid),
    .iReady(iReady),
    .oD    (oD),
    .oBout (oBout),
    .oZ    (oZ)
  );

`ifdef SUB_SERIAL_ABS_EN
  localparam int NegLat = 8;
`else
  localparam int NegLat = 4;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Present operands for one accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
    iA     = a;
    iB     = b;
    iBin   = bin;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!oValid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic [31:0] ed, input logic eb,
                        input logic ez, input int elat);
    int lat;
    start_op(a, b, bin);
    wait_valid(lat);
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    check({tag, ".d"}, oD, ed);
    check({tag, ".bout"}, {31'd0, oBout}, {31'd0, eb});
    check({tag, ".z"}, {31'd0, oZ}, {31'd0, ez});
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check({tag, ".ready_after"}, {31'd0, oReady}, 32'd1);
    check({tag, ".valid_after"}, {31'd0, oValid}, 32'd0);
  endtask

  initial begin
    int lat;
    iRst_n = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    iA     = '0;
    iB     = '0;
    iBin   = 1'b0;
    tick();
    tick();
    check("rst.ready", {31'd0, oReady}, 32'd1);
    check("rst.valid", {31'd0, oValid}, 32'd0);
    check("rst.d", oD, 32'd0);
    check("rst.bout", {31'd0, oBout}, 32'd0);
    check("rst.z", {31'd0, oZ}, 32'd0);
    iRst_n = 1'b1;
    tick();

    run_op("small", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 4);
    run_op("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 4);
    run_op("xslice", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 4);
    run_op("msb", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFE, 1'b0, 1'b0, 4);
    run_op("corner", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b1, NegLat);
`ifdef SUB_SERIAL_ABS_EN
    run_op("neg", 32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 8);
`else
    run_op("neg", 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 4);
`endif

    // Backpressure: result must hold while a competing request is presented.
    start_op(32'h0000_0100, 32'h0000_0001, 1'b0);
    wait_valid(lat);
    check("bp.lat", 32'(lat), 32'd4);
    iA     = 32'hDEAD_BEEF;
    iB     = 32'h0000_0001;
    iValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.d", oD, 32'h0000_00FF);
      check("bp.bout", {31'd0, oBout}, 32'd0);
      check("bp.z", {31'd0, oZ}, 32'd0);
      check("bp.ready", {31'd0, oReady}, 32'd0);
      check("bp.valid", {31'd0, oValid}, 32'd1);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("bp.release_ready", {31'd0, oReady}, 32'd1);
    tick();
    check("bp.still_idle", {31'd0, oReady}, 32'd1);

    // Reset while slice 2 is being processed.
    start_op(32'h1111_1111, 32'h0000_0001, 1'b0);
    tick();
    tick();
    iRst_n = 1'b0;
    tick();
    check("midrst.valid", {31'd0, oValid}, 32'd0);
    check("midrst.ready", {31'd0, oReady}, 32'd1);
    check("midrst.d", oD, 32'd0);
    check("midrst.bout", {31'd0, oBout}, 32'd0);
    check("midrst.z", {31'd0, oZ}, 32'd0);
    iRst_n = 1'b1;
    tick();
    run_op("postrst", 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 32'hF0F0_F0F0, 1'b0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
